coherence_mem_arbiter: RTL and testbench
========================================

Name: coherence_mem_arbiter

Overview:
- Coherence-aware memory arbiter that sits between the per-CPU instruction/data caches (CPUS=2) and the single-ported RAM.
- Grants one cache request at a time and drives the RAM strobes.
- For data reads, broadcasts snoops to the other CPU's dcache: read-exclusive invalidation, and cache-to-cache forwarding when the other cache holds the line Modified.
- Implements the controller side of the cache control interface.

Parameters:
CPUS, 2, number of processors (design and verification fixed at 2)
WORD_W, 32, data/address width (word_t)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
iREN  in  CPUS  icache read request per CPU
dREN  in  CPUS  dcache read request per CPU
dWEN  in  CPUS  dcache write(back) request per CPU
iaddr  in  CPUS*WORD_W  icache address per CPU
daddr  in  CPUS*WORD_W  dcache address per CPU
dstore  in  CPUS*WORD_W  dcache store data per CPU
ccwrite  in  CPUS  requester: read-exclusive; snooped cache: holds line Modified
cctrans  in  CPUS  cache state transition in progress
iwait  out  CPUS  icache stall, low for one cycle on completion
dwait  out  CPUS  dcache stall, low for one cycle on completion
iload  out  CPUS*WORD_W  instruction data
dload  out  CPUS*WORD_W  data load
ccwait  out  CPUS  snoop-target stall
ccinv  out  CPUS  snoop-target invalidate
ccsnoopaddr  out  CPUS*WORD_W  snoop address
ramload  in  WORD_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe

Behaviour:
- FSM states: IDLE, DWRITE, SNOOP, C2C, DREAD, IFETCH.
- Registered state: grant g (1 bit), last_grant (1 bit). All outputs are combinational from state/g.
- Reset (sampled on CLK edge): state=IDLE, g=0, last_grant=1.
- Default outputs: iwait=dwait=all 1s, ccwait=ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0. iload[n]=ramload for all n; dload[n]=ramload except in C2C.
- IDLE, arbitration:
  - Class priority: any dWEN > any dREN > any iREN.
  - Within a class: if both CPUs request, g = ~last_grant; otherwise g = the sole requester.
  - On grant, last_grant<=g.
  - Next state: dWEN→DWRITE, dREN→SNOOP, iREN→IFETCH.
  - A grant costs one IDLE cycle; no requests → stay in IDLE.
- DWRITE: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]. On ramstate==ACCESS: dwait[g]=0, →IDLE.
- SNOOP (exactly 1 cycle); o = ~g:
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g].
  - If ccwrite[o]==1 at end of cycle →C2C, else →DREAD.
- C2C: ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g].
  - Writeback: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[o], dload[g]=dstore[o].
  - On ACCESS: dwait[g]=0 and dwait[o]=0 in the same cycle, →IDLE.
- DREAD: ramREN=1, ramaddr=daddr[g]. On ACCESS: dwait[g]=0, →IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[g]. On ACCESS: iwait[g]=0, →IDLE.
- ramstate FREE/BUSY/ERROR: hold the current state and outputs. There is no timeout; ERROR is not ACCESS.
- Requests must stay asserted until their wait drops. A grant is never aborted by a request deasserting; the transaction completes.
- A new request arriving mid-transaction waits for IDLE; there is no preemption.
- Completion latency is (1 IDLE + [1 SNOOP] + N RAM cycles). The wait-low pulse is exactly 1 cycle.
- Mid-operation reset: next state is IDLE, so outputs return to default the cycle after reset is sampled. No partial completion pulse is produced.
- Never assert ramREN and ramWEN together; at most one CPU sees wait low per cycle, except in C2C.

Test Plan:
- Reset then idle: RST high for 2 cycles → all iwait/dwait=2'b11, ram strobes 0, ccwait=0.
- Single ifetch: CPU0 iREN, iaddr=0x100, RAM returns 0xDEADBEEF after 2 BUSY cycles → ramREN high with ramaddr=0x100; iwait[0] low one cycle with iload[0]=0xDEADBEEF.
- Class priority and round-robin:
  - CPU0 iREN and CPU1 dWEN together → CPU1 write (ramWEN, ramaddr=daddr[1]) served first.
  - Then both CPUs iREN → grants alternate 1,0,1 across three back-to-back requests.
- Read-exclusive snoop: CPU0 dREN, ccwrite[0]=1, daddr=0x200, ccwrite[1]=0 → SNOOP cycle with ccwait[1]=1, ccinv[1]=1, ccsnoopaddr[1]=0x200; then DREAD; dwait[0] low on ACCESS.
- Cache-to-cache: CPU1 dREN 0x300, CPU0 ccwrite=1 with dstore[0]=0xCAFE0001 → ramWEN writes 0xCAFE0001 to 0x300; dload[1]=0xCAFE0001; dwait[0] and dwait[1] low in the same cycle.
- Reset during DREAD with ramstate=BUSY → after reset, ramREN=0, dwait=2'b11, no completion pulse; a fresh request afterward completes normally.

Source files
------------

// File: rtl/coherence_mem_arbiter.sv
// Coherence-aware arbiter between two CPUs' instruction/data caches and one
// single-ported RAM. One cache transaction is served at a time. Data reads
// snoop the other CPU's dcache, which either invalidates that copy or, when it
// holds the line Modified, supplies the line cache-to-cache while the arbiter
// writes the line back to RAM.
module coherence_mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  input  logic [CPUS-1:0]          ccwrite,
  input  logic [CPUS-1:0]          cctrans,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN
);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    DWRITE,
    SNOOP,
    C2C,
    DREAD,
    IFETCH
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t          state;
  state_t          next_state;
  logic            g;
  logic            next_g;
  logic            last_grant;
  logic            next_last;
  logic            o;
  logic [CPUS-1:0] req;
  logic            snooping;
  logic            ram_done;
  word_t           ia_w [CPUS];
  word_t           da_w [CPUS];
  word_t           ds_w [CPUS];
  logic            cctrans_unused;

  // Transition status is informational only; the arbiter does not wait on it.
  assign cctrans_unused = ^cctrans;

  // The snooped cache is always the one that did not win the grant.
  assign o        = ~g;
  assign snooping = (state == SNOOP) || (state == C2C);
  assign ram_done = (ramstate == RAM_ACCESS);

  // Highest-priority request class: writebacks, then data reads, then fetches.
  assign req = (|dWEN) ? dWEN : ((|dREN) ? dREN : iREN);

  // Split the flat per-CPU buses into word arrays indexed by CPU number.
  always_comb begin
    for (int n = 0; n < CPUS; n++) begin
      ia_w[n] = iaddr[n*WORD_W +: WORD_W];
      da_w[n] = daddr[n*WORD_W +: WORD_W];
      ds_w[n] = dstore[n*WORD_W +: WORD_W];
    end
  end

  // State, current grant and round-robin history registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= next_state;
      g          <= next_g;
      last_grant <= next_last;
    end
  end

  // Arbitration, transaction sequencing and all combinational outputs.
  always_comb begin
    next_state = state;
    next_g     = g;
    next_last  = last_grant;
    iwait      = '1;
    dwait      = '1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iload      = '0;
    dload      = '0;
    ccwait     = '0;
    ccinv      = '0;
    ccsnoopaddr = '0;

    for (int n = 0; n < CPUS; n++) begin
      iload[n*WORD_W +: WORD_W] = ramload;
      dload[n*WORD_W +: WORD_W] = ((state == C2C) && (n[0] == g)) ? ds_w[o] : ramload;
      if (snooping && (n[0] == o)) begin
        ccwait[n] = 1'b1;
        ccinv[n]  = ccwrite[g];
        ccsnoopaddr[n*WORD_W +: WORD_W] = da_w[g];
      end
    end

    case (state)
      IDLE: begin
        if (|req) begin
          next_g    = (&req) ? ~last_grant : req[1];
          next_last = next_g;
          if (|dWEN)
            next_state = DWRITE;
          else if (|dREN)
            next_state = SNOOP;
          else
            next_state = IFETCH;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = da_w[g];
        ramstore = ds_w[g];
        if (ram_done) begin
          dwait[g]   = 1'b0;
          next_state = IDLE;
        end
      end
      SNOOP: begin
        next_state = ccwrite[o] ? C2C : DREAD;
      end
      C2C: begin
        ramWEN   = 1'b1;
        ramaddr  = da_w[g];
        ramstore = ds_w[o];
        if (ram_done) begin
          dwait[g]   = 1'b0;
          dwait[o]   = 1'b0;
          next_state = IDLE;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = da_w[g];
        if (ram_done) begin
          dwait[g]   = 1'b0;
          next_state = IDLE;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = ia_w[g];
        if (ram_done) begin
          iwait[g]   = 1'b0;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_mem_arbiter.sv
// Self-checking bench for coherence_mem_arbiter: a table of directed
// transactions, randomized traffic predicted by a transaction-level model of
// pending requests, and hand-written reset sequences.
module tb_coherence_mem_arbiter;

  localparam int K_IF  = 0;
  localparam int K_DW  = 1;
  localparam int K_DR  = 2;
  localparam int K_C2C = 3;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef struct {
    logic [1:0]        iren;
    logic [1:0]        dren;
    logic [1:0]        dwen;
    logic [1:0]        ccw;
    int                busy;
    logic [1:0][31:0]  ia;
    logic [1:0][31:0]  da;
    logic [1:0][31:0]  ds;
    logic [31:0]       rl;
    int                win;
    int                kind;
    logic [31:0]       addr;
    logic [31:0]       data;
    int                lat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait, ccwait, ccinv;
  logic [63:0] iload, dload, ccsnoopaddr;
  logic [31:0] ramload, ramaddr, ramstore;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: outstanding requests per CPU and arbitration history.
  logic        pi [2];
  int          pd [2];
  logic [31:0] mia [2];
  logic [31:0] mda [2];
  logic [31:0] mds [2];
  int          mlast;

  vec_t tbl [8];

  coherence_mem_arbiter #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramload(ramload), .ramstate(ramstate),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN)
  );

  // Free-running 10-time-unit clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] iren, input logic [1:0] dren,
                               input logic [1:0] dwen, input logic [1:0] ccw, input int busy,
                               input logic [31:0] ia0, input logic [31:0] ia1,
                               input logic [31:0] da0, input logic [31:0] da1,
                               input logic [31:0] ds0, input logic [31:0] ds1,
                               input logic [31:0] rl, input int win, input int kind,
                               input logic [31:0] addr, input logic [31:0] data, input int lat);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.ccw = ccw; v.busy = busy;
    v.ia[0] = ia0; v.ia[1] = ia1; v.da[0] = da0; v.da[1] = da1;
    v.ds[0] = ds0; v.ds[1] = ds1; v.rl = rl;
    v.win = win; v.kind = kind; v.addr = addr; v.data = data; v.lat = lat;
    return v;
  endfunction

  task automatic pulseReset();
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0;
    ramstate = RS_FREE;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Drive one transaction, act as the RAM, and compare the completion cycle.
  task automatic applyStimulus(input vec_t v);
    int         cyc;
    int         ram_cnt;
    logic       done;
    logic       dual;
    int         o;
    logic [1:0] ew_i;
    logic [1:0] ew_d;
    logic [1:0] estb;
    o = 1 - v.win;
    iREN = v.iren; dREN = v.dren; dWEN = v.dwen; ccwrite = v.ccw;
    iaddr = v.ia; daddr = v.da; dstore = v.ds; ramload = v.rl;
    ramstate = RS_FREE;
    cyc = 0; ram_cnt = 0; done = 1'b0; dual = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (ramREN || ramWEN) begin
        ramstate = (ram_cnt >= v.busy) ? RS_ACCESS : RS_BUSY;
        ram_cnt++;
      end else begin
        ramstate = RS_FREE;
      end
      #1;
      if (ramREN && ramWEN) dual = 1'b1;
      if (v.kind >= K_DR && cyc == 1) begin
        checkOutput("snoop_ccwait", 32'(ccwait), 32'(2'b01 << o));
        checkOutput("snoop_ccinv", 32'(ccinv[o]), 32'(v.ccw[v.win]));
        checkOutput("snoop_addr", ccsnoopaddr[o*32 +: 32], v.da[v.win]);
      end
      if (iwait !== 2'b11 || dwait !== 2'b11) done = 1'b1;
    end
    if (!done) begin
      checkOutput("timeout_latency", 32'(cyc), 32'(v.lat));
      pulseReset();
      return;
    end
    ew_i = 2'b11; ew_d = 2'b11;
    if (v.kind == K_IF) ew_i[v.win] = 1'b0;
    else if (v.kind == K_C2C) ew_d = 2'b00;
    else ew_d[v.win] = 1'b0;
    estb = (v.kind == K_IF || v.kind == K_DR) ? 2'b10 : 2'b01;
    checkOutput("latency", 32'(cyc), 32'(v.lat));
    checkOutput("iwait", 32'(iwait), 32'(ew_i));
    checkOutput("dwait", 32'(dwait), 32'(ew_d));
    checkOutput("strobes", 32'({ramREN, ramWEN}), 32'(estb));
    checkOutput("ramaddr", ramaddr, v.addr);
    checkOutput("dual_strobe", 32'(dual), 32'd0);
    case (v.kind)
      K_IF:    checkOutput("iload", iload[v.win*32 +: 32], v.data);
      K_DW:    checkOutput("ramstore", ramstore, v.data);
      K_DR:    checkOutput("dload", dload[v.win*32 +: 32], v.data);
      default: begin
        checkOutput("c2c_ramstore", ramstore, v.data);
        checkOutput("c2c_dload", dload[v.win*32 +: 32], v.data);
      end
    endcase
    @(posedge CLK); #1;
    ramstate = RS_FREE;
    checkOutput("pulse_width", 32'({iwait, dwait}), 32'hF);
  endtask

  // Refill outstanding requests at random and predict the next served transaction.
  task automatic buildRandom(output vec_t v);
    logic [1:0] iv, rv, wv, cls;
    int         w;
    for (int c = 0; c < 2; c++) begin
      if (!pi[c] && $urandom_range(0, 1) == 1) begin
        pi[c] = 1'b1; mia[c] = $urandom;
      end
      if (pd[c] == 0 && $urandom_range(0, 1) == 1) begin
        pd[c] = $urandom_range(1, 2); mda[c] = $urandom; mds[c] = $urandom;
      end
    end
    if (!pi[0] && !pi[1] && pd[0] == 0 && pd[1] == 0) begin
      w = $urandom_range(0, 1);
      pi[w] = 1'b1; mia[w] = $urandom;
    end
    for (int c = 0; c < 2; c++) begin
      iv[c] = pi[c];
      rv[c] = (pd[c] == 1);
      wv[c] = (pd[c] == 2);
      v.ia[c] = mia[c]; v.da[c] = mda[c]; v.ds[c] = mds[c];
    end
    v.iren = iv; v.dren = rv; v.dwen = wv;
    v.ccw  = 2'($urandom_range(0, 3));
    v.busy = $urandom_range(0, 3);
    v.rl   = $urandom;
    cls = (wv != 0) ? wv : ((rv != 0) ? rv : iv);
    w = (cls == 2'b11) ? (1 - mlast) : (cls[1] ? 1 : 0);
    mlast = w;
    v.win = w;
    if (wv != 0) begin
      v.kind = K_DW; v.addr = mda[w]; v.data = mds[w]; pd[w] = 0;
    end else if (rv != 0) begin
      v.kind = v.ccw[1 - w] ? K_C2C : K_DR;
      v.addr = mda[w];
      v.data = (v.kind == K_C2C) ? mds[1 - w] : v.rl;
      pd[w] = 0;
    end else begin
      v.kind = K_IF; v.addr = mia[w]; v.data = v.rl; pi[w] = 1'b0;
    end
    v.lat = v.busy + 1 + ((v.kind >= K_DR) ? 1 : 0);
  endtask

  initial begin
    vec_t v;
    logic seen_low;

    tbl[0] = mkv(2'b01, 2'b00, 2'b00, 2'b00, 2, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'hDEADBEEF, 0, K_IF, 32'h100, 32'hDEADBEEF, 3);
    tbl[1] = mkv(2'b01, 2'b00, 2'b10, 2'b00, 1, 32'h104, 32'h0, 32'h0, 32'h400, 32'h0, 32'h11112222,
                 32'h0, 1, K_DW, 32'h400, 32'h11112222, 2);
    tbl[2] = mkv(2'b01, 2'b00, 2'b00, 2'b00, 0, 32'h104, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'hA5A50003, 0, K_IF, 32'h104, 32'hA5A50003, 1);
    tbl[3] = mkv(2'b11, 2'b00, 2'b00, 2'b00, 1, 32'h108, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h44440004, 1, K_IF, 32'h208, 32'h44440004, 2);
    tbl[4] = mkv(2'b11, 2'b00, 2'b00, 2'b00, 0, 32'h108, 32'h20C, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h55550005, 0, K_IF, 32'h108, 32'h55550005, 1);
    tbl[5] = mkv(2'b11, 2'b00, 2'b00, 2'b00, 1, 32'h10C, 32'h20C, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h66660006, 1, K_IF, 32'h20C, 32'h66660006, 2);
    tbl[6] = mkv(2'b00, 2'b01, 2'b00, 2'b01, 0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0,
                 32'h77770007, 0, K_DR, 32'h200, 32'h77770007, 2);
    tbl[7] = mkv(2'b00, 2'b10, 2'b00, 2'b01, 1, 32'h0, 32'h0, 32'h0, 32'h300, 32'hCAFE0001, 32'h0,
                 32'h88880008, 1, K_C2C, 32'h300, 32'hCAFE0001, 3);

    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_iwait", 32'(iwait), 32'h3);
    checkOutput("reset_dwait", 32'(dwait), 32'h3);
    checkOutput("reset_strobes", 32'({ramREN, ramWEN}), 32'h0);
    checkOutput("reset_ccwait", 32'(ccwait), 32'h0);
    checkOutput("reset_ccinv", 32'(ccinv), 32'h0);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

    pulseReset();
    mlast = 1;
    for (int c = 0; c < 2; c++) begin
      pi[c] = 1'b0; pd[c] = 0; mia[c] = '0; mda[c] = '0; mds[c] = '0;
    end
    for (int i = 0; i < 60; i++) begin
      buildRandom(v);
      applyStimulus(v);
    end

    iREN = '0; dWEN = '0; dREN = 2'b01; ccwrite = '0;
    daddr = {32'h0, 32'h600}; ramstate = RS_BUSY;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checkOutput("mid_dread_ren", 32'(ramREN), 32'h1);
    RST = 1'b1; dREN = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    checkOutput("mid_reset_ren", 32'(ramREN), 32'h0);
    checkOutput("mid_reset_dwait", 32'(dwait), 32'h3);
    seen_low = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (iwait !== 2'b11 || dwait !== 2'b11 || ramREN || ramWEN) seen_low = 1'b1;
    end
    checkOutput("mid_reset_quiet", 32'(seen_low), 32'h0);
    ramstate = RS_FREE;
    applyStimulus(mkv(2'b00, 2'b11, 2'b00, 2'b00, 1, 32'h0, 32'h0, 32'h700, 32'h704, 32'h0, 32'h0,
                      32'h99990009, 0, K_DR, 32'h700, 32'h99990009, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
